// File: rtl/bram_pixel_stream_tx_if.sv
// AXI-Stream master channel that carries one packed lattice pixel per beat.
interface bram_pixel_stream_tx_if #(
    parameter int TDATA_WIDTH = 144
) ();
    logic                     tvalid;
    logic [TDATA_WIDTH-1:0]   tdata;
    logic [TDATA_WIDTH/8-1:0] tstrb;
    logic                     tlast;
    logic                     tready;

    modport master (output tvalid, tdata, tstrb, tlast, input tready);
    modport slave  (input tvalid, tdata, tstrb, tlast, output tready);
endinterface

// File: rtl/bram_pixel_stream_tx.sv
// Reads DEPTH pixels (9 lattice directions each) from BRAM and streams them as AXI-Stream beats.
// Optional macro PIXEL_TX_ZERO_FILL_EN adds fill_zero: stream an all-zero frame without BRAM reads.
module bram_pixel_stream_tx #(
    parameter int DATA_WIDTH             = 16,
    parameter int DEPTH                  = 2500,
    parameter int ADDRESS_WIDTH          = 12,
    parameter int C_M00_AXIS_TDATA_WIDTH = 144
) (
    input  logic                     m00_axis_aclk,
    input  logic                     m00_axis_areset,
    input  logic                     start,
`ifdef PIXEL_TX_ZERO_FILL_EN
    input  logic                     fill_zero,
`endif
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH-1:0] read_addr,
    output logic                     ren,
    input  logic [DATA_WIDTH-1:0]    n1,
    input  logic [DATA_WIDTH-1:0]    null1,
    input  logic [DATA_WIDTH-1:0]    ne1,
    input  logic [DATA_WIDTH-1:0]    e1,
    input  logic [DATA_WIDTH-1:0]    se1,
    input  logic [DATA_WIDTH-1:0]    s1,
    input  logic [DATA_WIDTH-1:0]    sw1,
    input  logic [DATA_WIDTH-1:0]    w1,
    input  logic [DATA_WIDTH-1:0]    nw1,
    bram_pixel_stream_tx_if.master   m00_axis
);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    wire clk = m00_axis_aclk;
    wire rst = m00_axis_areset;

    state_t state_q, state_d;

    logic [C_M00_AXIS_TDATA_WIDTH-1:0] fifo_data [2];
    logic                              fifo_last [2];
    logic                              wr_ptr, rd_ptr;
    logic [1:0]                        count;

    logic vld_p1, last_p1;
    logic zero_mode;
    logic issue, room, push, pop, full, head_last;
    logic [2:0] pending;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0] pixel;

    assign pixel = {nw1, w1, sw1, s1, se1, e1, ne1, null1, n1};

    assign full      = (count == 2'd2);
    assign push      = vld_p1;
    assign pop       = m00_axis.tvalid && m00_axis.tready;
    assign head_last = fifo_last[rd_ptr];

    // A slot being popped this cycle counts as free, which sustains one beat
    // per cycle; a full FIFO still blocks the read even if it is popping.
    assign pending = 3'(count) + 3'(vld_p1);
    assign room    = !full && (pending < (3'd2 + 3'(pop)));

    assign m00_axis.tvalid = (count != 2'd0);
    assign m00_axis.tdata  = m00_axis.tvalid ? fifo_data[rd_ptr] : '0;
    assign m00_axis.tlast  = m00_axis.tvalid && head_last;
    assign m00_axis.tstrb  = '1;

    assign ren = issue && !zero_mode;

`ifdef PIXEL_TX_ZERO_FILL_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_mode <= 1'b0;
        end else if (state_q == IDLE && start) begin
            zero_mode <= fill_zero;
        end
    end
`else
    assign zero_mode = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = STREAM;
            end
            STREAM: begin
                busy  = 1'b1;
                issue = room;
                if (room && read_addr == LAST_ADDR) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (pop && head_last) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            read_addr <= '0;
            vld_p1    <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                read_addr <= '0;
            end else if (issue && read_addr != LAST_ADDR) begin
                read_addr <= read_addr + 1'b1;
            end
            vld_p1 <= issue;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Stage boundary: BRAM word returns one cycle after the read and lands in the FIFO.
    always_ff @(posedge clk) begin
        last_p1 <= (read_addr == LAST_ADDR);
        if (push) begin
            fifo_data[wr_ptr] <= zero_mode ? '0 : pixel;
            fifo_last[wr_ptr] <= last_p1;
        end
    end
endmodule

// File: tb/tb_bram_pixel_stream_tx.sv
// Directed bench for bram_pixel_stream_tx with a frame-level reference model and per-cycle compare.
module tb_bram_pixel_stream_tx;
    localparam int DW = 16, DEPTH = 4, AW = 12, TW = 144;
    localparam logic [TW-1:0] LIT0 = 144'h0800_0700_0600_0500_0400_0300_0200_0100_0000;
    localparam logic [TW-1:0] LIT1 = 144'h0801_0701_0601_0501_0401_0301_0201_0101_0001;
    localparam logic [TW-1:0] LIT2 = 144'h0802_0702_0602_0502_0402_0302_0202_0102_0002;
    localparam logic [TW-1:0] LIT3 = 144'h0803_0703_0603_0503_0403_0303_0203_0103_0003;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic busy, done, ren;
    logic [AW-1:0] read_addr;
    logic [DW-1:0] n1, null1, ne1, e1, se1, s1, sw1, w1, nw1;
`ifdef PIXEL_TX_ZERO_FILL_EN
    logic fill_zero = 1'b0;
`endif

    bram_pixel_stream_tx_if #(.TDATA_WIDTH(TW)) axis ();

    bram_pixel_stream_tx #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDRESS_WIDTH(AW), .C_M00_AXIS_TDATA_WIDTH(TW)
    ) dut (
        .m00_axis_aclk(clk), .m00_axis_areset(rst), .start(start),
`ifdef PIXEL_TX_ZERO_FILL_EN
        .fill_zero(fill_zero),
`endif
        .busy(busy), .done(done), .read_addr(read_addr), .ren(ren),
        .n1(n1), .null1(null1), .ne1(ne1), .e1(e1), .se1(se1),
        .s1(s1), .sw1(sw1), .w1(w1), .nw1(nw1),
        .m00_axis(axis.master)
    );

    always #5 clk = ~clk;

    // Direction k of pixel a carries (k << 8) | a, so packing order is visible in tdata.
    function automatic logic [DW-1:0] dirv(int k, logic [AW-1:0] a);
        return DW'((k << 8) | int'(a));
    endfunction

    function automatic logic [TW-1:0] pix(int a);
        logic [TW-1:0] v;
        v = '0;
        for (int k = 0; k < 9; k++) v[k*DW +: DW] = dirv(k, AW'(a));
        return v;
    endfunction

    // BRAM: word valid exactly one cycle after ren, garbage otherwise.
    logic [AW-1:0] bram_a = '0;
    logic          bram_ok = 1'b0;
    always @(posedge clk) begin
        bram_ok <= ren;
        bram_a  <= read_addr;
    end
    assign n1    = bram_ok ? dirv(0, bram_a) : 16'hDEA0;
    assign null1 = bram_ok ? dirv(1, bram_a) : 16'hDEA1;
    assign ne1   = bram_ok ? dirv(2, bram_a) : 16'hDEA2;
    assign e1    = bram_ok ? dirv(3, bram_a) : 16'hDEA3;
    assign se1   = bram_ok ? dirv(4, bram_a) : 16'hDEA4;
    assign s1    = bram_ok ? dirv(5, bram_a) : 16'hDEA5;
    assign sw1   = bram_ok ? dirv(6, bram_a) : 16'hDEA6;
    assign w1    = bram_ok ? dirv(7, bram_a) : 16'hDEA7;
    assign nw1   = bram_ok ? dirv(8, bram_a) : 16'hDEA8;

    int checks = 0, failures = 0;
    int phase = 0, since = 0, beat_idx = 0, rd_idx = 0, issued = 0, accepted = 0;
    int done_cnt = 0, done_since = -1, first_tv = -1, ren_cnt = 0, occ = 0;
    bit strict = 1'b0, zmode = 1'b0, zero_req = 1'b0, rmode = 1'b0;
    bit prev_ren = 1'b0, prev_stall = 1'b0, prev_rst = 1'b0, acc = 1'b0;
    logic [TW-1:0] prev_data, cap [8];
    logic          prev_last, cap_last [8];

    task automatic chk(string name, logic [TW-1:0] act, logic [TW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // tready: constant 1, or the repeating 1,0,0,1 pattern.
    initial begin
        int pi = 0;
        axis.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rmode) begin
                axis.tready = (pi == 0 || pi == 3);
                pi = (pi + 1) % 4;
            end else begin
                axis.tready = 1'b1;
                pi = 0;
            end
        end
    end

    // Frame model: phase 0 idle, 1 frame in progress, 2 done cycle.
    always @(negedge clk) begin
        if (prev_rst) begin
            chk("rst_tvalid", axis.tvalid, 0);
            chk("rst_tlast", axis.tlast, 0);
            chk("rst_tdata", axis.tdata, 0);
            chk("rst_ren", ren, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
        end
        if (rst) begin
            phase = 0; since = 0; beat_idx = 0; rd_idx = 0; issued = 0; accepted = 0;
            prev_ren = 1'b0; prev_stall = 1'b0;
        end else begin
            if (phase != 0) since++;
            acc = axis.tvalid && axis.tready;
            chk("busy", busy, phase == 1);
            chk("done", done, phase == 2);
            if (done) begin done_cnt++; done_since = since; end
            if (phase != 1) begin
                chk("tvalid_outside_frame", axis.tvalid, 0);
                chk("ren_outside_frame", ren, 0);
            end else begin
                if (strict) chk("tvalid_timing", axis.tvalid, since >= 2 && since <= DEPTH + 1);
                if (zmode) chk("ren_zero_fill", ren, 0);
                if (axis.tvalid && first_tv < 0) first_tv = since;
            end
            if (prev_stall) begin
                chk("stall_tvalid", axis.tvalid, 1);
                chk("stall_tdata", axis.tdata, prev_data);
                chk("stall_tlast", axis.tlast, prev_last);
            end
            if (ren) begin
                ren_cnt++;
                occ = issued - accepted - (prev_ren ? 1 : 0);
                chk("ren_fifo_full", occ >= 2, 0);
                chk("read_addr", read_addr, rd_idx);
                rd_idx++; issued++;
            end
            if (acc) begin
                chk("beat_within_depth", beat_idx < DEPTH, 1);
                chk("beat_tdata", axis.tdata, zmode ? '0 : pix(beat_idx));
                chk("beat_tlast", axis.tlast, beat_idx == DEPTH - 1);
                if (beat_idx < 8) begin
                    cap[beat_idx] = axis.tdata;
                    cap_last[beat_idx] = axis.tlast;
                end
                beat_idx++; accepted++;
            end
            if (phase == 0 && start) begin
                phase = 1; since = -1; beat_idx = 0; rd_idx = 0; issued = 0; accepted = 0;
                first_tv = -1; ren_cnt = 0; zmode = zero_req;
            end else if (phase == 1 && acc && beat_idx == DEPTH) begin
                phase = 2;
            end else if (phase == 2) begin
                phase = 0;
            end
            prev_ren   = ren;
            prev_stall = axis.tvalid && !axis.tready;
            prev_data  = axis.tdata;
            prev_last  = axis.tlast;
        end
        prev_rst = rst;
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(bit z);
        start = 1'b1;
        zero_req = z;
`ifdef PIXEL_TX_ZERO_FILL_EN
        fill_zero = z;
`endif
        tick(1);
        start = 1'b0;
`ifdef PIXEL_TX_ZERO_FILL_EN
        fill_zero = 1'b0;
`endif
    endtask

    task automatic wait_frame(int d0);
        int n = 0;
        while (!(done_cnt > d0 && phase == 0) && n < 200) begin
            tick(1);
            n++;
        end
        if (n >= 200) begin
            checks++; failures++;
            $display("FAIL frame_timeout: done pulses=%0d required more than %0d", done_cnt, d0);
        end
    endtask

    initial begin
        int d0;
        int n;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);

        // Back-to-back frame with tready=1.
        strict = 1'b1;
        d0 = done_cnt;
        pulse_start(1'b0);
        wait_frame(d0);
        strict = 1'b0;
        chk("t1_beats", beat_idx, 4);
        chk("t1_done_pulses", done_cnt - d0, 1);
        chk("t1_first_tvalid", first_tv, 2);
        chk("t1_done_timing", done_since, 6);
        chk("t1_beat0", cap[0], LIT0);
        chk("t1_beat3", cap[3], LIT3);
        chk("t1_tlast2", cap_last[2], 0);
        chk("t1_tlast3", cap_last[3], 1);
        tick(2);

        // Backpressure 1,0,0,1.
        rmode = 1'b1;
        d0 = done_cnt;
        pulse_start(1'b0);
        wait_frame(d0);
        rmode = 1'b0;
        chk("t2_beats", beat_idx, 4);
        chk("t2_done_pulses", done_cnt - d0, 1);
        chk("t2_beat1", cap[1], LIT1);
        chk("t2_beat2", cap[2], LIT2);
        tick(2);

        // Extra start pulses while busy.
        d0 = done_cnt;
        pulse_start(1'b0);
        tick(1);
        pulse_start(1'b0);
        tick(1);
        pulse_start(1'b0);
        wait_frame(d0);
        tick(3);
        chk("t3_beats", beat_idx, 4);
        chk("t3_done_pulses", done_cnt - d0, 1);
        tick(2);

        // Reset after beat 1, then a clean frame.
        d0 = done_cnt;
        pulse_start(1'b0);
        n = 0;
        while (beat_idx < 2 && n < 50) begin
            tick(1);
            n++;
        end
        chk("t4_reached_beat1", beat_idx >= 2, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(4);
        chk("t4_no_done", done_cnt - d0, 0);
        d0 = done_cnt;
        pulse_start(1'b0);
        wait_frame(d0);
        chk("t4_beats", beat_idx, 4);
        chk("t4_beat0", cap[0], LIT0);
        chk("t4_beat3", cap[3], LIT3);
        tick(2);

`ifdef PIXEL_TX_ZERO_FILL_EN
        // Zero-fill frame.
        strict = 1'b1;
        d0 = done_cnt;
        pulse_start(1'b1);
        wait_frame(d0);
        strict = 1'b0;
        zero_req = 1'b0;
        chk("t5_beats", beat_idx, 4);
        chk("t5_ren_count", ren_cnt, 0);
        chk("t5_beat0", cap[0], 0);
        chk("t5_beat3", cap[3], 0);
        chk("t5_tlast3", cap_last[3], 1);
        chk("t5_done_pulses", done_cnt - d0, 1);
        tick(2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
